// File: rtl/mdu_dispatch_pkg.sv
// rtl/mdu_dispatch_pkg.sv - MDU op codes, micro-op/result types and routing helpers
`ifndef MDU_DISPATCH_PKG_SV
`define MDU_DISPATCH_PKG_SV

`define _MDU_MUL   3'b000
`define _MDU_MULH  3'b001
`define _MDU_MULHU 3'b010
`define _MDU_DIV   3'b011
`define _MDU_DIVU  3'b100
`define _MDU_MOD   3'b101
`define _MDU_MODU  3'b110

package mdu_dispatch_pkg;
  localparam int XLEN  = 32;
  localparam int REG_W = 6;
  localparam int OP_W  = 3;

  typedef struct packed {
    logic [OP_W-1:0]      op;
    logic [1:0][XLEN-1:0] data;
    logic [REG_W-1:0]     reg_id;
  } mdu_i_t;

  typedef struct packed {
    logic [XLEN-1:0]  data;
    logic [REG_W-1:0] reg_id;
  } mdu_o_t;

  function automatic logic is_mul_op(input logic [OP_W-1:0] op);
    return op inside {`_MDU_MUL, `_MDU_MULH, `_MDU_MULHU};
  endfunction

  function automatic logic is_div_op(input logic [OP_W-1:0] op);
    return op inside {`_MDU_DIV, `_MDU_DIVU, `_MDU_MOD, `_MDU_MODU};
  endfunction
endpackage

`endif

// File: rtl/mdu_res_fifo.sv
// rtl/mdu_res_fifo.sv - per-unit result buffer with registered head
module mdu_res_fifo
  import mdu_dispatch_pkg::*;
#(
  parameter int BUF_DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   clr,
  input  logic   push,
  input  logic   pop,
  input  mdu_o_t din,
  output logic   full,
  output logic   empty,
  output mdu_o_t head
);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  mdu_o_t           mem [BUF_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  // Explicit wrap so non-power-of-two depths stay inside the array.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  assign full  = (count == CNT_W'(BUF_DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
endmodule

// File: rtl/mdu_dispatch.sv
// rtl/mdu_dispatch.sv - routes MDU micro-ops to mul/div and arbitrates results onto writeback
module mdu_dispatch
  import mdu_dispatch_pkg::*;
#(
  parameter int BUF_DEPTH = 2,
  parameter int CNT_W     = $clog2(BUF_DEPTH + 1)
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   flush,
  input  mdu_i_t req_i,
  input  logic   req_valid_i,
  output logic   req_ready_o,
  output mdu_i_t mul_req_o,
  output logic   mul_valid_o,
  input  logic   mul_ready_i,
  input  mdu_o_t mul_res_i,
  input  logic   mul_res_valid_i,
  output logic   mul_res_ready_o,
  output mdu_i_t div_req_o,
  output logic   div_valid_o,
  input  logic   div_ready_i,
  input  mdu_o_t div_res_i,
  input  logic   div_res_valid_i,
  output logic   div_res_ready_o,
  output mdu_o_t wb_o,
  output logic   wb_valid_o,
  input  logic   wb_ready_i,
  output logic   busy_o
);
  logic [CNT_W-1:0] mul_cred, div_cred;
  logic   is_mul, is_div, mul_cred_ok, div_cred_ok;
  logic   mul_acc, div_acc, mul_push, div_push, mul_pop, div_pop;
  logic   mul_full, div_full, mul_empty, div_empty;
  mdu_o_t mul_head, div_head;
  logic   lock, lock_div, rr_div, sel_div, wb_hs, both;

  assign is_mul      = is_mul_op(req_i.op);
  assign is_div      = is_div_op(req_i.op);
  assign mul_cred_ok = (mul_cred < CNT_W'(BUF_DEPTH));
  assign div_cred_ok = (div_cred < CNT_W'(BUF_DEPTH));

  assign mul_req_o   = req_i;
  assign div_req_o   = req_i;
  // Unit valids are held low through reset regardless of the issue stage.
  assign mul_valid_o = rst_n & req_valid_i & is_mul & mul_cred_ok & !flush;
  assign div_valid_o = rst_n & req_valid_i & is_div & div_cred_ok & !flush;
  assign req_ready_o = !flush & (is_mul ? (mul_ready_i & mul_cred_ok) :
                                 is_div ? (div_ready_i & div_cred_ok) : 1'b1);
  assign mul_acc     = mul_valid_o & mul_ready_i;
  assign div_acc     = div_valid_o & div_ready_i;

  assign mul_res_ready_o = !mul_full;
  assign div_res_ready_o = !div_full;
  assign mul_push        = mul_res_valid_i & mul_res_ready_o & !flush;
  assign div_push        = div_res_valid_i & div_res_ready_o & !flush;

  mdu_res_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_mul_fifo (
    .clk(clk), .rst_n(rst_n), .clr(flush), .push(mul_push), .pop(mul_pop),
    .din(mul_res_i), .full(mul_full), .empty(mul_empty), .head(mul_head)
  );

  mdu_res_fifo #(.BUF_DEPTH(BUF_DEPTH)) u_div_fifo (
    .clk(clk), .rst_n(rst_n), .clr(flush), .push(div_push), .pop(div_pop),
    .din(div_res_i), .full(div_full), .empty(div_empty), .head(div_head)
  );

  // A stalled writeback keeps its source; otherwise round-robin only on contention.
  assign both = !mul_empty & !div_empty;
  always_comb begin
    sel_div = mul_empty;
    if (lock)      sel_div = lock_div;
    else if (both) sel_div = rr_div;
  end

  assign wb_valid_o = !mul_empty | !div_empty;
  assign wb_o       = sel_div ? div_head : mul_head;
  assign wb_hs      = wb_valid_o & wb_ready_i;
  assign mul_pop    = wb_hs & !sel_div;
  assign div_pop    = wb_hs & sel_div;
  assign busy_o     = (mul_cred != '0) | (div_cred != '0);

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      lock     <= 1'b0;
      lock_div <= 1'b0;
      rr_div   <= 1'b0;
      mul_cred <= '0;
      div_cred <= '0;
    end else begin
      lock     <= wb_valid_o & !wb_ready_i;
      lock_div <= sel_div;
      if (wb_hs && both) rr_div <= !rr_div;
      mul_cred <= mul_cred + CNT_W'(mul_acc) - CNT_W'(mul_pop);
      div_cred <= div_cred + CNT_W'(div_acc) - CNT_W'(div_pop);
    end
  end
endmodule

// File: tb/tb_mdu_dispatch.sv
// tb/tb_mdu_dispatch.sv - directed scoreboard bench for mdu_dispatch
module tb_mdu_dispatch;
  import mdu_dispatch_pkg::*;

  logic   clk = 1'b0;
  logic   rst_n, flush;
  mdu_i_t req, mul_req, div_req;
  logic   req_valid, req_ready, mul_valid, div_valid, mul_ready, div_ready;
  mdu_o_t mul_res, div_res, wb;
  logic   mul_res_valid, div_res_valid, mul_res_ready, div_res_ready;
  logic   wb_valid, wb_ready, busy;

  int     total = 0;
  int     passed = 0;
  mdu_o_t exp_q[$];

  always #5 clk = ~clk;

  mdu_dispatch #(.BUF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_i(req), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .mul_req_o(mul_req), .mul_valid_o(mul_valid), .mul_ready_i(mul_ready),
    .mul_res_i(mul_res), .mul_res_valid_i(mul_res_valid), .mul_res_ready_o(mul_res_ready),
    .div_req_o(div_req), .div_valid_o(div_valid), .div_ready_i(div_ready),
    .div_res_i(div_res), .div_res_valid_i(div_res_valid), .div_res_ready_o(div_res_ready),
    .wb_o(wb), .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .busy_o(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic mdu_o_t mk(input logic [5:0] rid, input logic [31:0] d);
    mdu_o_t r;
    r.reg_id = rid;
    r.data   = d;
    return r;
  endfunction

  // Monitor: every writeback handshake must match the next expected result.
  always @(negedge clk) begin
    if (rst_n && wb_valid && wb_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL wb_unexpected: got reg_id %0d data %0h, expected none", wb.reg_id, wb.data);
      end else begin
        mdu_o_t e;
        e = exp_q.pop_front();
        chk("wb_reg_id", 64'(wb.reg_id), 64'(e.reg_id));
        chk("wb_data", 64'(wb.data), 64'(e.data));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [5:0] rid);
    int n = 0;
    req.op = op; req.reg_id = rid; req.data[0] = 32'd2; req.data[1] = 32'd3;
    req_valid = 1'b1;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("issue_accept", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic res(input bit to_div, input mdu_o_t r);
    if (to_div) begin div_res = r; div_res_valid = 1'b1; end
    else begin mul_res = r; mul_res_valid = 1'b1; end
    idle(1);
    mul_res_valid = 1'b0; div_res_valid = 1'b0;
  endtask

  task automatic collide(input bit div_first, input logic [31:0] dm, input logic [31:0] dd);
    issue(`_MDU_MUL, 6'd3);
    issue(`_MDU_DIV, 6'd9);
    if (div_first) begin exp_q.push_back(mk(9, dd)); exp_q.push_back(mk(3, dm)); end
    else begin exp_q.push_back(mk(3, dm)); exp_q.push_back(mk(9, dd)); end
    mul_res = mk(3, dm); div_res = mk(9, dd);
    mul_res_valid = 1'b1; div_res_valid = 1'b1;
    idle(1);
    mul_res_valid = 1'b0; div_res_valid = 1'b0;
    idle(3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; req = '0; req_valid = 1'b1;
    mul_ready = 1'b1; div_ready = 1'b1; mul_res = '0; div_res = '0;
    mul_res_valid = 1'b0; div_res_valid = 1'b0; wb_ready = 1'b1;
    idle(2);
    @(negedge clk);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mul_valid", 64'(mul_valid), 64'd0);
    chk("rst_mul_res_ready", 64'(mul_res_ready), 64'd1);
    chk("rst_div_res_ready", 64'(div_res_ready), 64'd1);
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; rst_n = 1'b1;
    idle(1);

    // Single MUL with three-cycle unit latency.
    issue(`_MDU_MUL, 6'd5);
    @(negedge clk);
    chk("busy_after_issue", 64'(busy), 64'd1);
    idle(2);
    exp_q.push_back(mk(5, 32'h6));
    mul_res = mk(5, 32'h6); mul_res_valid = 1'b1;
    @(negedge clk);
    chk("wb_no_comb_path", 64'(wb_valid), 64'd0);
    @(posedge clk); #1;
    mul_res_valid = 1'b0;
    @(negedge clk);
    chk("wb_latency", 64'(wb_valid), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("busy_after_wb", 64'(busy), 64'd0);
    chk("wb_idle", 64'(wb_valid), 64'd0);
    idle(1);

    // Collisions: mul first, then div first, then mul first again.
    collide(1'b0, 32'h11, 32'h22);
    collide(1'b1, 32'h33, 32'h44);
    collide(1'b0, 32'h55, 32'h66);

    // Stalled writeback: mul head locked while rr points at div.
    wb_ready = 1'b0;
    issue(`_MDU_MUL, 6'd7);
    issue(`_MDU_DIV, 6'd8);
    exp_q.push_back(mk(7, 32'hAA));
    exp_q.push_back(mk(8, 32'hBB));
    res(1'b0, mk(7, 32'hAA));
    div_res = mk(8, 32'hBB); div_res_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("lock_valid", 64'(wb_valid), 64'd1);
      chk("lock_reg_id", 64'(wb.reg_id), 64'd7);
      chk("lock_data", 64'(wb.data), 64'hAA);
      @(posedge clk); #1;
      div_res_valid = 1'b0;
    end
    wb_ready = 1'b1;
    idle(4);

    // Credit limit: third MUL waits for a writeback.
    wb_ready = 1'b0;
    issue(`_MDU_MUL, 6'd1);
    issue(`_MDU_MUL, 6'd2);
    req.op = `_MDU_MUL; req.reg_id = 6'd3; req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("cred_block_ready", 64'(req_ready), 64'd0);
      chk("cred_block_valid", 64'(mul_valid), 64'd0);
      @(posedge clk); #1;
    end
    exp_q.push_back(mk(1, 32'h101));
    res(1'b0, mk(1, 32'h101));
    @(negedge clk);
    chk("cred_block_buffered", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    wb_ready = 1'b1;
    @(posedge clk); #1;
    wb_ready = 1'b0;
    @(negedge clk);
    chk("cred_release", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;

    // Flush with two buffered mul results and one div in flight.
    res(1'b0, mk(2, 32'h202));
    res(1'b0, mk(3, 32'h303));
    issue(`_MDU_DIV, 6'd4);
    @(negedge clk);
    chk("fifo_full", 64'(mul_res_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_no_accept", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_wb_valid", 64'(wb_valid), 64'd0);
    chk("flush_busy", 64'(busy), 64'd0);
    chk("flush_res_ready", 64'(mul_res_ready), 64'd1);
    @(posedge clk); #1;
    wb_ready = 1'b1;
    req.op = `_MDU_DIV; req.reg_id = 6'd10; req_valid = 1'b1;
    @(negedge clk);
    chk("post_flush_ready", 64'(req_ready), 64'd1);
    chk("post_flush_div_valid", 64'(div_valid), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    exp_q.push_back(mk(10, 32'h50));
    res(1'b1, mk(10, 32'h50));
    idle(3);

    // Illegal op is accepted and dropped.
    req.op = 3'b111; req.reg_id = 6'd12; req_valid = 1'b1;
    @(negedge clk);
    chk("illegal_ready", 64'(req_ready), 64'd1);
    chk("illegal_mul_valid", 64'(mul_valid), 64'd0);
    chk("illegal_div_valid", 64'(div_valid), 64'd0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    idle(3);
    @(negedge clk);
    chk("illegal_no_wb", 64'(wb_valid), 64'd0);
    chk("illegal_not_busy", 64'(busy), 64'd0);

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/mdu_dispatch.md
Name: mdu_dispatch

Overview:
- Front-end controller for the multiply/divide unit.
- Accepts one MDU micro-op per cycle from the issue stage and routes it by opcode to the multiplier or the divider. It is the initiator on each unit's req/valid/ready interface.
- Captures each unit's result into a per-unit result FIFO, then round-robin arbitrates the FIFO heads onto the single MDU writeback port toward the ROB/CDB.

Parameters:
- BUF_DEPTH, 2: result FIFO entries per unit; also the credit limit per unit (in-flight plus buffered).
- CNT_W, $clog2(BUF_DEPTH+1): credit counter width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- flush  in  1  pipeline flush; discards all MDU state
- req_i  in  mdu_i_t  op, data[0], data[1], reg_id from issue
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request accepted when valid and ready are both high
- mul_req_o  out  mdu_i_t  req_i forwarded to the multiplier
- mul_valid_o  out  1  request valid to the multiplier
- mul_ready_i  in  1  multiplier can accept
- mul_res_i  in  mdu_o_t  multiplier result
- mul_res_valid_i  in  1  multiplier result valid
- mul_res_ready_o  out  1  result FIFO can capture
- div_req_o, div_valid_o, div_ready_i, div_res_i, div_res_valid_i, div_res_ready_o: same as the mul_* set, for the divider
- wb_o  out  mdu_o_t  writeback data and reg_id
- wb_valid_o  out  1  writeback valid
- wb_ready_i  in  1  writeback sink ready
- busy_o  out  1  any credit outstanding

Behaviour:
- Routing:
  - `_MDU_MUL, `_MDU_MULH, `_MDU_MULHU go to mul.
  - `_MDU_DIV, `_MDU_DIVU, `_MDU_MOD, `_MDU_MODU go to div.
  - Any other op goes to neither unit and is accepted and dropped (req_ready_o=1).
- Forward path is combinational: mul_req_o = div_req_o = req_i.
- mul_valid_o = req_valid_i & is_mul & (mul_cred < BUF_DEPTH) & !flush. div_valid_o is symmetric.
- req_ready_o = !flush & (is_mul ? mul_ready_i & mul_cred<BUF_DEPTH : is_div ? div_ready_i & div_cred<BUF_DEPTH : 1).
- Credits (per unit):
  - +1 on an accepted request; -1 on a writeback handshake granted to that unit.
  - Both in the same cycle leaves the count unchanged.
  - Counter never exceeds BUF_DEPTH, so a unit is never stalled by its FIFO.
- Result FIFO (per unit):
  - Depth BUF_DEPTH; res_ready_o = !full.
  - Push on res_valid_i & res_ready_o & !flush; pop on writeback grant.
  - Push and pop in the same cycle are allowed at any occupancy except push when full.
  - Pointers wrap modulo BUF_DEPTH.
- Writeback arbitration:
  - wb_valid_o = !mul_empty | !div_empty, driven from registered FIFO heads with no combinational path from unit results.
  - If only one FIFO is non-empty, it is selected.
  - If both are non-empty, the rr pointer selects; pointer resets to mul and toggles after each handshake made while both were non-empty.
  - Lock: once wb_valid_o=1 with wb_ready_i=0, the selection and wb_o hold stable until handshake.
- busy_o = (mul_cred!=0) | (div_cred!=0).
- Flush: in the flush cycle there is no accept and no push. On the next edge, credits=0, FIFOs empty, lock=0, rr=mul. The units receive flush from the top level separately.
- Reset values: wb_valid_o=0, busy_o=0, mul/div_valid_o=0 (flush-independent), res_ready_o=1, req_ready_o follows its equation. Reset mid-operation behaves identically to flush.
- Latency: the result appears on wb_o one cycle after capture at the earliest.

Decomposition:
- Add to the shared defines/package: the `_MDU_DIV/DIVU/MOD/MODU op codes next to the existing `_MDU_MUL* codes. mdu_i_t and mdu_o_t are reused unchanged.
- Add is_mul_op/is_div_op helper functions to the package.
- One sub-module, mdu_res_fifo (parameter BUF_DEPTH; push/pop/full/empty/head), instantiated once per unit.

Test Plan:
- Single MUL, reg_id=5, ideal mul stub returning data 0x0000_0006 three cycles later -> wb_valid_o one cycle after capture, wb_o.reg_id=5, data=0x6, busy_o drops after the handshake.
- Mul and div stubs both return results on the same cycle (reg_id 3 and 9), wb_ready_i=1 -> reg_id 3 first, then 9. Repeat the collision -> 9 first.
- wb_ready_i=0 for 4 cycles while div results arrive behind a pending mul result -> wb_o stays reg_id/data of the mul entry, stable, until ready rises.
- BUF_DEPTH=2, mul stub always ready, wb_ready_i=0, issue 3 MULs back-to-back -> first two accepted, req_ready_o=0 for the third until one writeback completes.
- Flush with 2 buffered results and 1 in flight -> next cycle wb_valid_o=0, busy_o=0; a new DIV is accepted immediately.
- Illegal op 3'b111 with valid -> req_ready_o=1, no unit valid, no writeback.
